// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: store-size and load funct3
// codes, FSM state type, and helpers for access width and alignment.
package lsu_pkg;

    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } lsu_state_t;

    // Loads take their width from funct3[1:0]; the unused codes
    // 011/110/111 fall into the word case.
    function automatic logic [1:0] access_width(
        input logic [1:0] size,
        input logic [2:0] f3
    );
        logic [1:0] w;
        if (size != SZ_LOAD) begin
            w = size;
        end else if (f3[1]) begin
            w = SZ_W;
        end else begin
            w = f3[1:0];
        end
        return w;
    endfunction

    function automatic logic is_aligned(
        input logic [1:0] width,
        input logic [1:0] lo
    );
        logic ok;
        case (width)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load result formatter: picks the byte/halfword lane from a bus word and
// sign- or zero-extends it. Ports: i_rdata, i_addr_lo, i_funct3 -> o_data.
module lsu_load_format
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Load/store unit: one handshaked bus transaction per memory instruction,
// stalling the core until done; returns formatted load data.
// Ports: core side (memory_en, store_size, funct3, addr, store_data ->
// stall, load_data, load_valid, misaligned, bus_err); bus side (mem_req,
// mem_we, mem_addr, mem_wdata, mem_wstrb <- mem_ready, mem_rdata, mem_rvalid).
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            memory_en,
    input  logic [1:0]      store_size,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misaligned,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_is_load;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic [2:0]      r_funct3;
    logic            r_err;
    logic [XLEN-1:0] r_load_data;

    logic            w_is_load;
    logic [1:0]      w_width;
    logic            w_aligned;
    logic            w_accept;
    logic            w_cnt_last;
    logic            w_timeout_hit;
    logic            w_rvalid_take;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_fmt;
    logic            w_idle;
    logic            w_req;
    logic            w_wait;
    logic            w_done;

    assign w_is_load  = (store_size == SZ_LOAD);
    assign w_width    = access_width(store_size, funct3);
    assign w_aligned  = is_aligned(w_width, addr[1:0]);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_req      = (r_state == ST_REQ);
    assign w_wait     = (r_state == ST_WAIT_R);
    assign w_done     = (r_state == ST_DONE);
    assign w_accept   = w_idle & memory_en & w_aligned;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Store lane replication; loads carry no write data or strobes.
    always_comb begin
        w_wdata = '0;
        w_wstrb = 4'b0000;
        if (!w_is_load) begin
            case (store_size)
                SZ_B: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_wstrb = 4'b0001 << addr[1:0];
                end
                SZ_H: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_wstrb = 4'b0011 << {addr[1], 1'b0};
                end
                default: begin
                    w_wdata = store_data;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // A completed handshake in the last allowed cycle still counts; a load
    // whose request is only accepted then has no time left for data.
    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        w_rvalid_take = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready && !r_is_load) begin
                    w_next = ST_DONE;
                end else if (w_cnt_last) begin
                    w_next        = ST_DONE;
                    w_timeout_hit = 1'b1;
                end else if (mem_ready) begin
                    w_next = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    w_next        = ST_DONE;
                    w_rvalid_take = 1'b1;
                end else if (w_cnt_last) begin
                    w_next        = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    lsu_load_format #(
        .XLEN(XLEN)
    ) u_fmt (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_fmt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_load   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 4'b0000;
            r_funct3    <= 3'b000;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_req || w_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_is_load <= w_is_load;
                r_addr    <= addr;
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
                r_funct3  <= funct3;
                r_err     <= 1'b0;
            end
            if (w_timeout_hit) r_err <= 1'b1;
            if (w_rvalid_take) r_load_data <= w_fmt;
        end
    end

    assign stall      = w_accept | w_req | w_wait;
    assign misaligned = w_idle & memory_en & ~w_aligned;
    assign mem_req    = w_req;
    assign mem_we     = w_req & ~r_is_load;
    assign mem_addr   = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata  = w_req ? r_wdata : '0;
    assign mem_wstrb  = w_req ? r_wstrb : 4'b0000;
    assign load_valid = w_done & r_is_load & ~r_err;
    assign bus_err    = w_done & r_err;
    assign load_data  = r_load_data;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Testbench for lsu_mem_responder: transaction-level model drives expected
// outputs each cycle; directed cases pin literal results.
module tb_lsu_mem_responder;

    localparam int T = 255;

    logic        CLK = 1'b0;
    logic        RST;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    always #5 CLK = ~CLK;

    lsu_mem_responder #(
        .XLEN(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .memory_en  (memory_en),
        .store_size (store_size),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic        e_stall, e_lv, e_mis, e_berr, e_req, e_we;
    logic [31:0] e_ld, e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    int          n_stall, n_req, n_lv, n_mis, n_berr;
    logic [31:0] cap_wdata, cap_addr;
    logic [3:0]  cap_wstrb;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("stall", {31'b0, stall}, {31'b0, e_stall});
            chk("load_valid", {31'b0, load_valid}, {31'b0, e_lv});
            chk("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
            chk("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
            chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_wstrb});
            chk("load_data", load_data, e_ld);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            if (stall)      n_stall++;
            if (load_valid) n_lv++;
            if (misaligned) n_mis++;
            if (bus_err)    n_berr++;
            if (mem_req) begin
                n_req++;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
                cap_addr  = mem_addr;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_idle();
        e_stall = 1'b0;
        e_lv    = 1'b0;
        e_mis   = 1'b0;
        e_berr  = 1'b0;
        e_req   = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        e_wstrb = 4'b0000;
    endtask

    task automatic clr_counts();
        n_stall = 0;
        n_req   = 0;
        n_lv    = 0;
        n_mis   = 0;
        n_berr  = 0;
    endtask

    function automatic logic [31:0] m_fmt(input logic [2:0] f3,
                                          input logic [1:0] lo,
                                          input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * lo);
        if (f3 == 3'b000) return {{24{s[7]}}, s[7:0]};
        if (f3 == 3'b001) return {{16{s[15]}}, s[15:0]};
        if (f3 == 3'b100) return {24'b0, s[7:0]};
        if (f3 == 3'b101) return {16'b0, s[15:0]};
        return rd;
    endfunction

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            memory_en  = 1'b0;
            store_size = 2'($urandom_range(0, 3));
            funct3     = 3'($urandom_range(0, 7));
            addr       = $urandom;
            store_data = $urandom;
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            exp_idle();
            step();
        end
    endtask

    // k: REQ cycle (1-based) in which mem_ready rises, 0 = never.
    // w: WAIT_R cycle (1-based) in which mem_rvalid rises, 0 = never.
    task automatic access(input bit ld, input logic [1:0] ss,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int k, input int w,
                          input logic [31:0] rd);
        int          sz, spent, wc, phase, nxt;
        bit          ok, err, ldd;
        logic [31:0] ew;
        logic [3:0]  es;
        sz = ld ? (f3[1] ? 2 : int'(f3[1:0])) : int'(ss);
        ok = (sz == 0) || (sz == 1 && !a[0]) || (sz == 2 && a[1:0] == 2'b00);
        memory_en  = 1'b1;
        store_size = ld ? 2'b11 : ss;
        funct3     = f3;
        addr       = a;
        store_data = d;
        mem_ready  = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        exp_idle();
        if (!ok) begin
            e_mis = 1'b1;
            step();
            return;
        end
        e_stall = 1'b1;
        step();
        ew = '0;
        es = 4'b0000;
        if (!ld) begin
            if (ss == 2'b00) begin
                ew = {24'b0, d[7:0]} * 32'h0101_0101;
                es = 4'b0001 << a[1:0];
            end else if (ss == 2'b01) begin
                ew = {16'b0, d[15:0]} * 32'h0001_0001;
                es = 4'b0011 << a[1:0];
            end else begin
                ew = d;
                es = 4'b1111;
            end
        end
        spent = 0;
        wc    = 0;
        err   = 1'b0;
        ldd   = 1'b0;
        phase = 1;
        while (phase != 3) begin
            spent++;
            mem_rdata = $urandom;
            exp_idle();
            e_stall = 1'b1;
            if (phase == 1) begin
                mem_ready  = (spent == k);
                mem_rvalid = 1'($urandom_range(0, 1));
                e_req   = 1'b1;
                e_we    = !ld;
                e_addr  = {a[31:2], 2'b00};
                e_wdata = ew;
                e_wstrb = es;
                if (spent == k && !ld)  nxt = 3;
                else if (spent == T)    nxt = 4;
                else if (spent == k)    nxt = 2;
                else                    nxt = 1;
            end else begin
                wc++;
                mem_ready  = 1'($urandom_range(0, 1));
                mem_rvalid = (wc == w);
                if (wc == w) begin
                    mem_rdata = rd;
                    ldd       = 1'b1;
                    nxt       = 3;
                end else if (spent == T) begin
                    nxt = 4;
                end else begin
                    nxt = 2;
                end
            end
            step();
            if (nxt == 4) begin
                err   = 1'b1;
                phase = 3;
            end else begin
                phase = nxt;
            end
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        exp_idle();
        if (ldd) e_ld = m_fmt(f3, a[1:0], rd);
        e_lv   = ld && !err;
        e_berr = err;
        step();
    endtask

    initial begin
        bit          ld;
        logic [1:0]  ss;
        logic [2:0]  f3;
        logic [31:0] a;
        RST        = 1'b1;
        memory_en  = 1'b0;
        store_size = 2'b00;
        funct3     = 3'b000;
        addr       = '0;
        store_data = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        exp_idle();
        e_ld = '0;
        clr_counts();
        step();
        step();
        step();
        RST    = 1'b0;
        chk_en = 1'b1;
        gap(2);

        clr_counts();
        access(1'b0, 2'b10, 3'b000, 32'h104, 32'hDEAD_BEEF, 2, 0, 0);
        chk("sw_stall_cycles", n_stall, 3);
        chk("sw_wstrb", {28'b0, cap_wstrb}, 32'h0000_000F);
        chk("sw_addr", cap_addr, 32'h0000_0104);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("sw_no_lv", n_lv, 0);
        gap(1);

        access(1'b0, 2'b00, 3'b000, 32'h103, 32'h0000_00A5, 1, 0, 0);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_wstrb", {28'b0, cap_wstrb}, 32'h0000_0008);

        access(1'b1, 2'b11, 3'b000, 32'h202, 0, 1, 1, 32'h12F4_5678);
        chk("lb_data", load_data, 32'hFFFF_FFF4);
        access(1'b1, 2'b11, 3'b100, 32'h202, 0, 2, 3, 32'h12F4_5678);
        chk("lbu_data", load_data, 32'h0000_00F4);
        access(1'b1, 2'b11, 3'b101, 32'h202, 0, 1, 2, 32'h12F4_5678);
        chk("lhu_data", load_data, 32'h0000_12F4);

        clr_counts();
        access(1'b1, 2'b11, 3'b010, 32'h106, 0, 1, 1, 0);
        gap(2);
        chk("lw_mis_pulses", n_mis, 1);
        chk("lw_mis_no_req", n_req, 0);

        clr_counts();
        access(1'b1, 2'b11, 3'b010, 32'h400, 0, 0, 0, 0);
        gap(1);
        chk("to_req_stall", n_stall, T + 1);
        chk("to_req_berr", n_berr, 1);
        chk("to_req_no_lv", n_lv, 0);
        chk("to_req_ld_kept", load_data, 32'h0000_12F4);

        clr_counts();
        access(1'b1, 2'b11, 3'b001, 32'h402, 0, 3, 0, 0);
        gap(1);
        chk("to_wait_stall", n_stall, T + 1);
        chk("to_wait_berr", n_berr, 1);
        chk("to_wait_no_lv", n_lv, 0);

        clr_counts();
        memory_en  = 1'b1;
        store_size = 2'b11;
        funct3     = 3'b010;
        addr       = 32'h300;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        exp_idle();
        e_stall = 1'b1;
        step();
        mem_ready = 1'b1;
        exp_idle();
        e_stall = 1'b1;
        e_req   = 1'b1;
        e_addr  = 32'h300;
        step();
        mem_ready = 1'b0;
        exp_idle();
        e_stall = 1'b1;
        step();
        RST    = 1'b1;
        chk_en = 1'b0;
        step();
        RST        = 1'b0;
        memory_en  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        exp_idle();
        e_ld   = '0;
        chk_en = 1'b1;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("rst_no_lv", n_lv, 0);
        chk("rst_ld_zero", load_data, 32'h0);

        for (int i = 0; i < 300; i++) begin
            ld = 1'($urandom_range(0, 1));
            ss = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b010;
                3:       f3 = 3'b100;
                4:       f3 = 3'b101;
                5:       f3 = 3'b011;
                6:       f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            a = $urandom;
            access(ld, ss, f3, a, $urandom, $urandom_range(1, 4),
                   $urandom_range(1, 4), $urandom);
            gap($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
